// File: rtl/jk_bank_scheduler.sv
// Round-robin scheduler that applies one JK operation at a time to a shared bank of JK cells.
// Each granted op runs IDLE -> APPLY (one-hot J/K strobes) -> ACK (gnt pulse).
module jk_bank_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [IDX_W*NREQ-1:0] req_idx,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      j_out,
  output logic [WIDTH-1:0]      k_out,
  output logic [WIDTH-1:0]      q,
  output logic                  busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  owner;
  logic [PTR_W-1:0]  pick;
  logic              any_req;
  logic [1:0]        op_q;
  logic [IDX_W-1:0]  idx_q;
  logic              idx_ok;
  logic [WIDTH-1:0]  sel;

  // Out-of-range indices still run the full handshake but select no cell.
  assign idx_ok = (32'(idx_q) < WIDTH);
  assign sel    = idx_ok ? (WIDTH'(1) << idx_q) : '0;

  // Round-robin search: first requester at or after the pointer, wrapping.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    any_req = 1'b0;
    pick    = '0;
    for (int i = 0; i < NREQ; i++) begin
      int cand;
      cand = (32'(ptr) + i) % NREQ;
      if (req[cand] && !any_req) begin
        any_req = 1'b1;
        pick    = PTR_W'(cand);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req) state_nxt = S_APPLY;
      S_APPLY: state_nxt = S_ACK;
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    j_out = '0;
    k_out = '0;
    gnt   = '0;
    busy  = 1'b0;
    case (state)
      S_APPLY: begin
        j_out = op_q[1] ? sel : '0;
        k_out = op_q[0] ? sel : '0;
        busy  = 1'b1;
      end
      S_ACK: begin
        gnt[owner] = 1'b1;
        busy       = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: grant latch, bank update, pointer advance
  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      ptr   <= '0;
      owner <= '0;
      op_q  <= '0;
      idx_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            owner <= pick;
            op_q  <= req_op[2*pick +: 2];
            idx_q <= req_idx[IDX_W*pick +: IDX_W];
          end
        end
        // JK characteristic equation; strobes are zero outside the selected cell.
        S_APPLY: q <= (j_out & ~q) | (~k_out & q);
        S_ACK:   ptr <= (owner == PTR_W'(NREQ - 1)) ? '0 : owner + PTR_W'(1);
        default: ;
      endcase
    end
  end

endmodule
